cnn_layer_accel_octo_map_sched: RTL and testbench
=================================================

# cnn_layer_accel_octo_map_sched

Map-level scheduler in front of `C_NUM_OCTO` octo BRAM controllers sharing one input word stream. It accepts map jobs, picks a free controller round-robin, and pulses that controller's `new_map`. It then steers the stream to the controller: first the sequencer words tagged as sequence data, then the pixel words tagged as pixel data. It tracks each controller until it returns to idle and reports completion per controller.

## Interface
- `C_NUM_OCTO`, 4, number of octo controllers scheduled (≥2)
- `C_BRAM_DEPTH`, 1024, BRAM depth of each controller; W = clog2(C_BRAM_DEPTH)−1, SW = clog2((C_BRAM_DEPTH/2)*5)
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `job_valid`  in  1  job descriptor valid
- `job_rdy`  out  1  job accepted when `job_valid && job_rdy`
- `job_numRows`  in  W  last row index (rows = value+1)
- `job_numCols`  in  W  last column index (cols = value+1)
- `job_seqLen`  in  SW+1  sequencer word count (0 allowed)
- `src_valid`  in  1  upstream word valid
- `src_rdy`  out  1  upstream word consumed when `src_valid && src_rdy`
- `cur_octo`  out  clog2(C_NUM_OCTO)  target index; drives the external data-bus mux
- `octo_new_map`  out  C_NUM_OCTO  one-cycle start pulse per controller
- `octo_datain_valid`  out  C_NUM_OCTO  per-controller valid
- `octo_seq_datain_tag`, `octo_pixel_datain_tag`  out  1 each  broadcast phase tags
- `octo_seq_datain_rdy`, `octo_pixel_datain_rdy`  in  C_NUM_OCTO each  controller readies
- `octo_idle`  in  C_NUM_OCTO  controller state is idle
- `busy`  out  C_NUM_OCTO  controller owns an unfinished job
- `done_valid`  out  1  one-cycle completion pulse
- `done_id`  out  clog2(C_NUM_OCTO)  index of the completed controller

## Operation
- FSM states:
  - `S_IDLE`: `job_rdy` = (`busy` != all-ones).
  - On accept: latch the descriptor; `cur_octo` = first free index after the last granted, wrapping. → `S_ISSUE`.
  - `S_ISSUE`: one cycle.
    - Registered `octo_new_map[cur_octo]` = 1; set `busy[cur_octo]`.
    - Register pix_total = (numRows+1)*(numCols+1), 18 bits.
    - → `S_SEQ`, or → `S_PIX` if seqLen = 0.
  - `S_SEQ`:
    - `octo_seq_datain_tag` = 1.
    - `octo_datain_valid[cur_octo]` = `src_valid`; `src_rdy` = `octo_seq_datain_rdy[cur_octo]`.
    - Count consumed words; on the consume of word seqLen → `S_PIX`.
  - `S_PIX`:
    - Same as `S_SEQ`, but with the pixel tag and pixel rdy.
    - On the consume of word pix_total → `S_IDLE`.
- Valid, tag and rdy paths are combinational from state; all other outputs are registered.
- In `S_IDLE`/`S_ISSUE`: `src_rdy` = 0, all `octo_datain_valid` = 0, both tags = 0.
- Completion tracking, per controller i:
  - `started[i]` sets when `busy[i] && !octo_idle[i]`.
  - When `started[i] && octo_idle[i]`: clear `busy[i]` and `started[i]`, set `pend[i]`.
  - The `new_map` cycle does not count as idle-after-start.
- Done arbitration: each cycle, if `pend` != 0, pulse `done_valid` with `done_id` = lowest set index, and clear that bit. Further pends wait for later cycles.
- Reset values: `state` = `S_IDLE`; `cur_octo` = 0; last-grant = C_NUM_OCTO−1; counters, `busy`, `started`, `pend`, `octo_new_map`, `done_valid`, `done_id` = 0.

## Timing
- Job accepted at cycle T → `octo_new_map` high at T+1 only → first word eligible at T+2.
- Word counters increment only on `src_valid && src_rdy`. The phase changes on the cycle after the final consume.
- `job_rdy` is high no earlier than the cycle after the last pixel consume.
- Controller returns idle at cycle C → `pend` at C+1 → `done_valid` at C+1 at the earliest.
- Simultaneous events:
  - A completion and a job accept on the same controller in one cycle: completion is processed first, so the controller is selectable on that cycle.
  - A completion during streaming does not disturb the stream.
- Reset asserted mid-job: all state clears immediately. The external controllers must be reset together with this block.
- `src_valid` may drop at any time; the stream simply stalls with counts preserved.

## Structure
- Shared package holds:
  - state encoding `S_IDLE`, `S_ISSUE`, `S_SEQ`, `S_PIX`;
  - width functions W and SW;
  - pix_total width 18, matching the controller pfb count.
- One sub-module, `cnn_layer_accel_rr_pick`: combinational round-robin first-free selector over `C_NUM_OCTO` bits from a last-grant pointer. It is reused for job grant. Done uses fixed lowest-index priority inline.

## Test plan
- Reset, then job (rows 2, cols 3, seqLen 5), all readies tied high:
  - `octo_new_map` = 4'b0001 one cycle after accept;
  - 5 seq-tagged then 12 pixel-tagged consumes;
  - `job_rdy` returns.
- Four back-to-back jobs with controllers held non-idle → grants 0,1,2,3; fifth job sees `job_rdy` = 0 until one controller goes idle.
- seqLen = 0 → `S_ISSUE` goes directly to `S_PIX`; seq tag never asserted.
- Toggle pixel rdy every other cycle and drop `src_valid` randomly → exactly pix_total consumes, no duplicates.
- Controllers 1 and 3 return idle in the same cycle → `done_valid` on two consecutive cycles, `done_id` 1 then 3; `busy` clears both.
- Assert reset during `S_PIX` → all outputs at reset values asynchronously; next job is granted to controller 0.

Source files
------------

// File: rtl/cnn_layer_accel_octo_map_sched_pkg.sv
// Shared types and width helpers for the octo map scheduler.
// The pixel total width matches the controller's pixel-fetch-buffer count.
package cnn_layer_accel_octo_map_sched_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_SEQ   = 2'd2,
      S_PIX   = 2'd3
   } sched_state_t;

   localparam int PIX_TOTAL_W = 18;

   function automatic int f_row_w(input int depth);
      return $clog2(depth) - 1;
   endfunction

   function automatic int f_seq_w(input int depth);
      return $clog2((depth / 2) * 5);
   endfunction

endpackage

// File: rtl/cnn_layer_accel_rr_pick.sv
// Round-robin first-free selector: lowest index strictly after i_last, wrapping,
// whose i_free bit is set. o_found is low when no bit of i_free is set.
module cnn_layer_accel_rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0]         i_free,
   input  logic [$clog2(N)-1:0] i_last,
   output logic [$clog2(N)-1:0] o_idx,
   output logic                 o_found
);

   localparam int IW = $clog2(N);

   int v_idx;

   // Scan from the farthest candidate back toward i_last+1 so the nearest wins.
   always_comb begin
      o_idx   = i_last;
      o_found = 1'b0;
      v_idx   = 0;
      for (int k = N; k >= 1; k--) begin
         v_idx = (int'(i_last) + k) % N;
         if (i_free[v_idx]) begin
            o_idx   = IW'(v_idx);
            o_found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cnn_layer_accel_octo_map_sched.sv
// Map-level scheduler: grants jobs to free octo controllers round-robin, steers the
// shared word stream (sequencer words, then pixels) and reports per-controller completion.
module cnn_layer_accel_octo_map_sched
   import cnn_layer_accel_octo_map_sched_pkg::*;
#(
   parameter int C_NUM_OCTO   = 4,
   parameter int C_BRAM_DEPTH = 1024
) (
   input  logic                                 i_clk,
   input  logic                                 i_rst,
   input  logic                                 i_job_valid,
   output logic                                 o_job_rdy,
   input  logic [f_row_w(C_BRAM_DEPTH)-1:0]     i_job_numRows,
   input  logic [f_row_w(C_BRAM_DEPTH)-1:0]     i_job_numCols,
   input  logic [f_seq_w(C_BRAM_DEPTH):0]       i_job_seqLen,
   input  logic                                 i_src_valid,
   output logic                                 o_src_rdy,
   output logic [$clog2(C_NUM_OCTO)-1:0]        o_cur_octo,
   output logic [C_NUM_OCTO-1:0]                o_octo_new_map,
   output logic [C_NUM_OCTO-1:0]                o_octo_datain_valid,
   output logic                                 o_octo_seq_datain_tag,
   output logic                                 o_octo_pixel_datain_tag,
   input  logic [C_NUM_OCTO-1:0]                i_octo_seq_datain_rdy,
   input  logic [C_NUM_OCTO-1:0]                i_octo_pixel_datain_rdy,
   input  logic [C_NUM_OCTO-1:0]                i_octo_idle,
   output logic [C_NUM_OCTO-1:0]                o_busy,
   output logic                                 o_done_valid,
   output logic [$clog2(C_NUM_OCTO)-1:0]        o_done_id
);

   localparam int N  = C_NUM_OCTO;
   localparam int W  = f_row_w(C_BRAM_DEPTH);
   localparam int SW = f_seq_w(C_BRAM_DEPTH);
   localparam int IW = $clog2(N);
   localparam int CW = (PIX_TOTAL_W > SW + 1) ? PIX_TOTAL_W : SW + 1;

   sched_state_t           r_state;
   logic [IW-1:0]          r_cur, r_last;
   logic [W-1:0]           r_rows, r_cols;
   logic [SW:0]            r_seq_len;
   logic [PIX_TOTAL_W-1:0] r_pix_total;
   logic [CW-1:0]          r_cnt;
   logic [N-1:0]           r_busy, r_started, r_pend, r_new_map;
   logic                   r_done_valid;
   logic [IW-1:0]          r_done_id;

   logic [N-1:0]           w_complete, w_busy_eff, w_pick_oh, w_issue_oh;
   logic [N-1:0]           w_pend_all, w_done_oh;
   logic [IW-1:0]          w_pick, w_done_idx;
   logic                   w_found, w_accept, w_fire, w_seq_last, w_pix_last;
   logic [CW-1:0]          w_cnt_nxt;
   logic [PIX_TOTAL_W-1:0] w_rows_n, w_cols_n, w_pix_prod;

   // A controller finishing this cycle is already free for a grant this cycle.
   assign w_complete = r_started & i_octo_idle;
   assign w_busy_eff = r_busy & ~w_complete;

   cnn_layer_accel_rr_pick #(.N(N)) u_pick (
      .i_free  (~w_busy_eff),
      .i_last  (r_last),
      .o_idx   (w_pick),
      .o_found (w_found)
   );

   assign o_job_rdy  = (r_state == S_IDLE) && w_found;
   assign w_accept   = i_job_valid && o_job_rdy;
   assign w_pick_oh  = {{(N-1){1'b0}}, 1'b1} << w_pick;
   assign w_issue_oh = (r_state == S_ISSUE) ? ({{(N-1){1'b0}}, 1'b1} << r_cur) : '0;

   assign w_rows_n   = PIX_TOTAL_W'(r_rows) + PIX_TOTAL_W'(1);
   assign w_cols_n   = PIX_TOTAL_W'(r_cols) + PIX_TOTAL_W'(1);
   assign w_pix_prod = w_rows_n * w_cols_n;

   always_comb begin
      o_src_rdy               = 1'b0;
      o_octo_datain_valid     = '0;
      o_octo_seq_datain_tag   = 1'b0;
      o_octo_pixel_datain_tag = 1'b0;
      case (r_state)
         S_SEQ: begin
            o_octo_seq_datain_tag      = 1'b1;
            o_src_rdy                  = i_octo_seq_datain_rdy[r_cur];
            o_octo_datain_valid[r_cur] = i_src_valid;
         end
         S_PIX: begin
            o_octo_pixel_datain_tag    = 1'b1;
            o_src_rdy                  = i_octo_pixel_datain_rdy[r_cur];
            o_octo_datain_valid[r_cur] = i_src_valid;
         end
         default: ;
      endcase
   end

   assign w_fire     = i_src_valid && o_src_rdy;
   assign w_cnt_nxt  = r_cnt + CW'(1);
   assign w_seq_last = (w_cnt_nxt == CW'(r_seq_len));
   assign w_pix_last = (w_cnt_nxt == CW'(r_pix_total));

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state     <= S_IDLE;
         r_cur       <= '0;
         r_last      <= IW'(N - 1);
         r_rows      <= '0;
         r_cols      <= '0;
         r_seq_len   <= '0;
         r_pix_total <= '0;
         r_cnt       <= '0;
         r_new_map   <= '0;
      end else begin
         r_new_map <= '0;
         case (r_state)
            S_IDLE: if (w_accept) begin
               r_rows    <= i_job_numRows;
               r_cols    <= i_job_numCols;
               r_seq_len <= i_job_seqLen;
               r_cur     <= w_pick;
               r_last    <= w_pick;
               r_new_map <= w_pick_oh;
               r_state   <= S_ISSUE;
            end
            S_ISSUE: begin
               r_pix_total <= w_pix_prod;
               r_cnt       <= '0;
               r_state     <= (r_seq_len == '0) ? S_PIX : S_SEQ;
            end
            S_SEQ: if (w_fire) begin
               if (w_seq_last) begin
                  r_cnt   <= '0;
                  r_state <= S_PIX;
               end else begin
                  r_cnt <= w_cnt_nxt;
               end
            end
            S_PIX: if (w_fire) begin
               if (w_pix_last) begin
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= w_cnt_nxt;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Lowest pending index wins; the rest stay pending for later cycles.
   assign w_pend_all = r_pend | w_complete;
   assign w_done_oh  = w_pend_all & (~w_pend_all + {{(N-1){1'b0}}, 1'b1});

   always_comb begin
      w_done_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (w_pend_all[i]) w_done_idx = IW'(i);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_busy       <= '0;
         r_started    <= '0;
         r_pend       <= '0;
         r_done_valid <= 1'b0;
         r_done_id    <= '0;
      end else begin
         r_busy       <= w_busy_eff | w_issue_oh;
         r_started    <= (r_started | (r_busy & ~i_octo_idle)) & ~w_complete;
         r_pend       <= w_pend_all & ~w_done_oh;
         r_done_valid <= |w_pend_all;
         r_done_id    <= w_done_idx;
      end
   end

   assign o_cur_octo     = r_cur;
   assign o_octo_new_map = r_new_map;
   assign o_busy         = r_busy;
   assign o_done_valid   = r_done_valid;
   assign o_done_id      = r_done_id;

endmodule

// File: tb/tb_cnn_layer_accel_octo_map_sched.sv
// Bench for the octo map scheduler: directed job table, random jobs against a
// round-robin/word-count model, plus completion, back-pressure and reset sequences.
module tb_cnn_layer_accel_octo_map_sched;

   localparam int N  = 4;
   localparam int W  = 9;
   localparam int SW = 12;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          job_valid, job_rdy;
   logic [W-1:0]  rows, cols;
   logic [SW:0]   seq_len;
   logic          src_valid, src_rdy;
   logic [1:0]    cur_octo, done_id;
   logic [N-1:0]  new_map, dvalid, seq_rdy, pix_rdy, idle, busy;
   logic          seq_tag, pix_tag, done_valid;

   int            n_cmp = 0;
   int            n_bad = 0;
   logic [N-1:0]  busy_m;
   int            last_m;

   typedef struct {
      int rows;
      int cols;
      int seq;
      int mode;
      int exp_g;
      int exp_pix;
   } vec_t;

   vec_t vecs[5];

   always #5 clk = ~clk;

   cnn_layer_accel_octo_map_sched #(.C_NUM_OCTO(N), .C_BRAM_DEPTH(1024)) dut (
      .i_clk                   (clk),
      .i_rst                   (rst_n),
      .i_job_valid             (job_valid),
      .o_job_rdy               (job_rdy),
      .i_job_numRows           (rows),
      .i_job_numCols           (cols),
      .i_job_seqLen            (seq_len),
      .i_src_valid             (src_valid),
      .o_src_rdy               (src_rdy),
      .o_cur_octo              (cur_octo),
      .o_octo_new_map          (new_map),
      .o_octo_datain_valid     (dvalid),
      .o_octo_seq_datain_tag   (seq_tag),
      .o_octo_pixel_datain_tag (pix_tag),
      .i_octo_seq_datain_rdy   (seq_rdy),
      .i_octo_pixel_datain_rdy (pix_rdy),
      .i_octo_idle             (idle),
      .o_busy                  (busy),
      .o_done_valid            (done_valid),
      .o_done_id               (done_id)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // Round-robin rule: first non-busy index after the previous grant, wrapping.
   function automatic int pick(input logic [N-1:0] b, input int last);
      for (int k = 1; k <= N; k++)
         if (!b[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0; job_valid = 1'b0; src_valid = 1'b0;
      seq_rdy = '1; pix_rdy = '1; idle = '1;
      rows = '0; cols = '0; seq_len = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      busy_m = '0; last_m = N - 1;
   endtask

   task automatic release_octo(input int g);
      nxt(); idle[g] = 1'b1;
      @(negedge clk);
      nxt();
      @(negedge clk);
      busy_m[g] = 1'b0;
      chk("done_valid", done_valid, 1);
      chk("done_id", done_id, g);
      chk("release_busy", busy, busy_m);
      nxt();
      @(negedge clk);
      chk("done_once", done_valid, 0);
   endtask

   // mode 0: everything ready; mode 1: random src_valid/seq rdy, pixel rdy toggling.
   task automatic run_job(input int r, input int c, input int s, input int mode,
                          input int exp_g, input int exp_pix, input int rel, input int fin);
      int to, nseq, npix, bad, cyc;
      logic [N-1:0] ev;
      nxt();
      if (rel >= 0) begin idle[rel] = 1'b1; busy_m[rel] = 1'b0; end
      rows = W'(r); cols = W'(c); seq_len = (SW+1)'(s); job_valid = 1'b1; src_valid = 1'b0;
      to = 0;
      @(negedge clk);
      while (!job_rdy && to < 300) begin nxt(); @(negedge clk); to++; end
      chk("job_rdy", job_rdy, 1);
      if (rel >= 0) chk("same_cycle_grant", to, 0);
      nxt(); job_valid = 1'b0;
      @(negedge clk);
      chk("new_map", new_map, 1 << exp_g);
      chk("cur_octo", cur_octo, exp_g);
      chk("issue_quiet", {seq_tag, pix_tag, src_rdy, dvalid}, 0);
      busy_m[exp_g] = 1'b1; last_m = exp_g;
      nseq = 0; npix = 0; bad = 0; cyc = 0;
      while (nseq + npix < s + exp_pix && cyc < 4000) begin
         nxt();
         idle[exp_g] = 1'b0;
         if (mode == 0) begin
            src_valid = 1'b1; seq_rdy = '1; pix_rdy = '1;
         end else begin
            src_valid = ($urandom_range(0, 3) != 0);
            seq_rdy   = N'($urandom);
            pix_rdy   = cyc[0] ? '1 : '0;
         end
         @(negedge clk);
         if (cyc == 0 && new_map != '0) bad++;
         ev = src_valid ? (N'(1) << exp_g) : '0;
         if (nseq < s) begin
            if ({seq_tag, pix_tag, src_rdy, dvalid} !== {2'b10, seq_rdy[exp_g], ev}) bad++;
         end else begin
            if ({seq_tag, pix_tag, src_rdy, dvalid} !== {2'b01, pix_rdy[exp_g], ev}) bad++;
         end
         if (src_valid && src_rdy) begin
            if (nseq < s) nseq++; else npix++;
         end
         cyc++;
      end
      chk("seq_count", nseq, s);
      chk("pix_count", npix, exp_pix);
      chk("stream_err", bad, 0);
      nxt(); src_valid = 1'b1;
      @(negedge clk);
      chk("post_quiet", {seq_tag, pix_tag, src_rdy, dvalid}, 0);
      chk("post_busy", busy, busy_m);
      chk("post_job_rdy", job_rdy, busy_m != '1);
      src_valid = 1'b0;
      if (fin != 0) release_octo(exp_g);
   endtask

   initial begin
      int b;
      int r, c, s, g;
      vecs[0] = '{2, 3, 5, 0, 0, 12};
      vecs[1] = '{0, 0, 0, 1, 1, 1};
      vecs[2] = '{4, 1, 0, 1, 2, 10};
      vecs[3] = '{1, 2, 3, 1, 3, 6};
      vecs[4] = '{3, 0, 1, 1, 0, 4};

      do_reset();
      @(negedge clk);
      chk("rst_state", {busy, new_map, done_valid, done_id, cur_octo, src_rdy, seq_tag, pix_tag, dvalid}, 0);
      chk("rst_job_rdy", job_rdy, 1);

      for (int i = 0; i < 5; i++)
         run_job(vecs[i].rows, vecs[i].cols, vecs[i].seq, vecs[i].mode,
                 vecs[i].exp_g, vecs[i].exp_pix, -1, 1);

      for (int j = 0; j < 12; j++) begin
         if (busy_m == '1) release_octo(int'($urandom_range(0, N - 1)));
         r = int'($urandom_range(0, 5));
         c = int'($urandom_range(0, 5));
         s = int'($urandom_range(0, 6));
         g = pick(busy_m, last_m);
         run_job(r, c, s, 1, g, (r + 1) * (c + 1), -1, int'($urandom_range(0, 1)));
      end

      // Fill every controller, then a fifth job must wait for a completion.
      do_reset();
      for (int k = 0; k < N; k++) run_job(1, 1, 2, 0, k, 4, -1, 0);
      rows = 9'd1; cols = 9'd0; seq_len = 13'd1; job_valid = 1'b1;
      b = 0;
      repeat (4) begin nxt(); @(negedge clk); if (job_rdy) b++; end
      chk("full_no_rdy", b, 0);
      run_job(1, 0, 1, 1, 2, 2, 2, 0);

      // Controllers 1 and 3 finish together.
      nxt(); idle[1] = 1'b1; idle[3] = 1'b1;
      @(negedge clk);
      chk("pre_done", done_valid, 0);
      nxt(); @(negedge clk);
      chk("dual_done0_v", done_valid, 1);
      chk("dual_done0_id", done_id, 1);
      chk("dual_busy", busy, 4'b0101);
      nxt(); @(negedge clk);
      chk("dual_done1_v", done_valid, 1);
      chk("dual_done1_id", done_id, 3);
      nxt(); @(negedge clk);
      chk("dual_done_end", done_valid, 0);
      busy_m = 4'b0101;

      // Reset asserted while streaming pixels to controller 3.
      nxt(); rows = 9'd1; cols = 9'd1; seq_len = 13'd2; job_valid = 1'b1;
      @(negedge clk);
      chk("mid_job_rdy", job_rdy, 1);
      nxt(); job_valid = 1'b0;
      @(negedge clk);
      chk("mid_new_map", new_map, 4'b1000);
      repeat (3) begin
         nxt(); idle[3] = 1'b0; src_valid = 1'b1; seq_rdy = '1; pix_rdy = '1;
         @(negedge clk);
      end
      chk("mid_in_pix", pix_tag, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst", {busy, new_map, done_valid, done_id, cur_octo, src_rdy, seq_tag, pix_tag, dvalid}, 0);
      @(posedge clk);
      #1;
      idle = '1; src_valid = 1'b0; rst_n = 1'b1;
      busy_m = '0; last_m = N - 1;
      run_job(0, 0, 0, 1, 0, 1, -1, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
